// File: rtl/instr_decode_stage.sv
// RV32I decode stage with one output register, a RAW scoreboard indexed by rd,
// and a saturating counter of cycles lost to operand hazards.
module instr_decode_stage #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    localparam int REG_AW  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_type,
    output logic [7:0]        out_ctrl,
    output logic [REG_AW-1:0] out_rd,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_pc,
    output logic              out_illegal,
    output logic [15:0]       stall_cnt
);

    localparam int SB_N = 1 << REG_AW;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] TY_R = 3'd0;
    localparam logic [2:0] TY_I = 3'd1;
    localparam logic [2:0] TY_S = 3'd2;
    localparam logic [2:0] TY_B = 3'd3;
    localparam logic [2:0] TY_U = 3'd4;
    localparam logic [2:0] TY_J = 3'd5;
    localparam logic [2:0] TY_N = 3'd7;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [2:0]        dec_type;
    logic [7:0]        dec_ctrl;
    logic              dec_legal;
    logic              dec_shift;
    logic [31:0]       dec_imm32;
    logic [XLEN-1:0]   dec_imm;
    logic [REG_AW-1:0] dec_rd, dec_rs1, dec_rs2;

    logic              hazard, accept;

    logic [SB_N-1:0]   busy_q, busy_d;
    logic              out_valid_q, out_valid_d;
    logic [2:0]        out_type_q, out_type_d;
    logic [7:0]        out_ctrl_q, out_ctrl_d;
    logic [REG_AW-1:0] out_rd_q, out_rd_d, out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
    logic [XLEN-1:0]   out_imm_q, out_imm_d, out_pc_q, out_pc_d;
    logic              out_illegal_q, out_illegal_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    assign opcode  = in_instr[6:0];
    assign funct3  = in_instr[14:12];
    assign dec_rd  = REG_AW'(in_instr[11:7]);
    assign dec_rs1 = REG_AW'(in_instr[19:15]);
    assign dec_rs2 = REG_AW'(in_instr[24:20]);

    // The opcode compare covers instr[1:0], so a non-32-bit encoding lands in default.
    always_comb begin
        dec_type  = TY_N;
        dec_ctrl  = 8'h00;
        dec_legal = 1'b1;
        case (opcode)
            OPC_LOAD:     begin dec_type = TY_I; dec_ctrl = 8'b1101_0100; end
            OPC_MISC_MEM: begin dec_type = TY_I; dec_ctrl = 8'b0000_0000; end
            OPC_OP_IMM:   begin dec_type = TY_I; dec_ctrl = 8'b1101_0000; end
            OPC_AUIPC:    begin dec_type = TY_U; dec_ctrl = 8'b1001_0001; end
            OPC_STORE:    begin dec_type = TY_S; dec_ctrl = 8'b0111_0010; end
            OPC_OP:       begin dec_type = TY_R; dec_ctrl = 8'b1110_0000; end
            OPC_LUI:      begin dec_type = TY_U; dec_ctrl = 8'b1001_0001; end
            OPC_BRANCH:   begin dec_type = TY_B; dec_ctrl = 8'b0111_1000; end
            OPC_JALR:     begin dec_type = TY_I; dec_ctrl = 8'b1101_1001; end
            OPC_JAL:      begin dec_type = TY_J; dec_ctrl = 8'b1001_1001; end
            OPC_SYSTEM:   begin dec_type = TY_I; dec_ctrl = 8'b0000_0000; end
            default:      dec_legal = 1'b0;
        endcase
    end

    assign dec_shift = (opcode == OPC_OP_IMM) && (funct3 == 3'b001 || funct3 == 3'b101);

    always_comb begin
        dec_imm32 = 32'h0;
        case (dec_type)
            TY_I: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            TY_S: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            TY_B: dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
            TY_U: dec_imm32 = {in_instr[31:12], 12'h000};
            TY_J: dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
            default: dec_imm32 = 32'h0;
        endcase
        // Shift amounts ignore funct7 (e.g. SRAI's bit 30) and are never negative.
        if (dec_shift) dec_imm32 = {27'h0, in_instr[24:20]};
    end

    assign dec_imm = XLEN'($signed(dec_imm32));

    assign hazard   = in_valid & dec_legal &
                      ((dec_ctrl[6] & busy_q[dec_rs1]) | (dec_ctrl[5] & busy_q[dec_rs2]));
    assign in_ready = !rst & !flush & !hazard & (!out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    // Set is applied after clear so a retiring rd re-claimed this cycle stays busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) busy_d[wb_rd] = 1'b0;
        if (accept && dec_legal && dec_ctrl[7] && dec_rd != '0) busy_d[dec_rd] = 1'b1;
        if (flush) busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_type_d    = out_type_q;
        out_ctrl_d    = out_ctrl_q;
        out_rd_d      = out_rd_q;
        out_rs1_d     = out_rs1_q;
        out_rs2_d     = out_rs2_q;
        out_imm_d     = out_imm_q;
        out_pc_d      = out_pc_q;
        out_illegal_d = out_illegal_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            out_type_d    = dec_type;
            out_ctrl_d    = dec_ctrl;
            out_rd_d      = dec_rd;
            out_rs1_d     = dec_rs1;
            out_rs2_d     = dec_rs2;
            out_imm_d     = dec_imm;
            out_pc_d      = in_pc;
            out_illegal_d = !dec_legal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !flush && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            out_valid_q   <= 1'b0;
            out_type_q    <= TY_N;
            out_ctrl_q    <= 8'h00;
            out_rd_q      <= '0;
            out_rs1_q     <= '0;
            out_rs2_q     <= '0;
            out_imm_q     <= '0;
            out_pc_q      <= '0;
            out_illegal_q <= 1'b0;
            stall_cnt_q   <= 16'h0;
        end else begin
            busy_q        <= busy_d;
            out_valid_q   <= out_valid_d;
            out_type_q    <= out_type_d;
            out_ctrl_q    <= out_ctrl_d;
            out_rd_q      <= out_rd_d;
            out_rs1_q     <= out_rs1_d;
            out_rs2_q     <= out_rs2_d;
            out_imm_q     <= out_imm_d;
            out_pc_q      <= out_pc_d;
            out_illegal_q <= out_illegal_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_type    = out_type_q;
    assign out_ctrl    = out_ctrl_q;
    assign out_rd      = out_rd_q;
    assign out_rs1     = out_rs1_q;
    assign out_rs2     = out_rs2_q;
    assign out_imm     = out_imm_q;
    assign out_pc      = out_pc_q;
    assign out_illegal = out_illegal_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: XLEN=32 and XLEN=64 copies share stimulus; fixed
// vectors, hand-written hazard/flush/backpressure sequences, then a random run.
module tb_instr_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready, wb_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic [4:0]  wb_rd;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [2:0]  a_out_type;
    logic [7:0]  a_out_ctrl;
    logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
    logic [31:0] a_out_imm, a_out_pc;
    logic [15:0] a_stall_cnt;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [2:0]  b_out_type;
    logic [7:0]  b_out_ctrl;
    logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
    logic [63:0] b_out_imm, b_out_pc;
    logic [15:0] b_stall_cnt;

    instr_decode_stage #(.XLEN(32), .NUM_REGS(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_type(a_out_type),
        .out_ctrl(a_out_ctrl), .out_rd(a_out_rd), .out_rs1(a_out_rs1), .out_rs2(a_out_rs2),
        .out_imm(a_out_imm), .out_pc(a_out_pc), .out_illegal(a_out_illegal),
        .stall_cnt(a_stall_cnt)
    );

    instr_decode_stage #(.XLEN(64), .NUM_REGS(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_type(b_out_type),
        .out_ctrl(b_out_ctrl), .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
        .out_imm(b_out_imm), .out_pc(b_out_pc), .out_illegal(b_out_illegal),
        .stall_cnt(b_stall_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        flush = 1'b1; in_valid = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  ty;
        logic [7:0]  ctrl;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    typedef struct {
        bit        legal;
        bit [2:0]  ty;
        bit [7:0]  ctrl;
        bit [63:0] imm;
    } dec_t;

    // Reference decode: table lookup plus immediates rebuilt by weighted bit sums.
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t   d;
        longint v;
        d.legal = 1'b1;
        case (w[6:0])
            7'h03:   begin d.ty = 3'd1; d.ctrl = 8'hD4; end
            7'h0F:   begin d.ty = 3'd1; d.ctrl = 8'h00; end
            7'h13:   begin d.ty = 3'd1; d.ctrl = 8'hD0; end
            7'h17:   begin d.ty = 3'd4; d.ctrl = 8'h91; end
            7'h23:   begin d.ty = 3'd2; d.ctrl = 8'h72; end
            7'h33:   begin d.ty = 3'd0; d.ctrl = 8'hE0; end
            7'h37:   begin d.ty = 3'd4; d.ctrl = 8'h91; end
            7'h63:   begin d.ty = 3'd3; d.ctrl = 8'h78; end
            7'h67:   begin d.ty = 3'd1; d.ctrl = 8'hD9; end
            7'h6F:   begin d.ty = 3'd5; d.ctrl = 8'h99; end
            7'h73:   begin d.ty = 3'd1; d.ctrl = 8'h00; end
            default: begin d.ty = 3'd7; d.ctrl = 8'h00; d.legal = 1'b0; end
        endcase
        v = 0;
        case (d.ty)
            3'd1: begin
                v = longint'(w[31:20]);
                if (w[31]) v -= 4096;
                if (w[6:0] == 7'h13 && (w[14:12] == 3'b001 || w[14:12] == 3'b101))
                    v = longint'(w[24:20]);
            end
            3'd2: begin
                v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
                if (w[31]) v -= 4096;
            end
            3'd3: begin
                v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                  + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
                if (w[31]) v -= 8192;
            end
            3'd4: begin
                v = longint'(w[31:12]) * 4096;
                if (w[31]) v -= 64'sh1_0000_0000;
            end
            3'd5: begin
                v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
                  + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
                if (w[31]) v -= 2097152;
            end
            default: v = 0;
        endcase
        d.imm = v;
        return d;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [6:0]  ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                  7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) != 0) begin
            w[6:0]   = ops[$urandom_range(0, 10)];
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
        end
        return w;
    endfunction

    // Model state for the random phase.
    bit        m_valid;
    dec_t      m_d;
    bit [31:0] m_instr;
    bit [63:0] m_pc;
    bit [31:0] m_busy;
    int        m_stall;

    task automatic rand_cycle();
        dec_t d;
        bit   haz, rdy, acc;
        in_valid  = ($urandom_range(0, 3) != 0);
        in_instr  = gen_instr();
        in_pc     = {$urandom, $urandom};
        out_ready = ($urandom_range(0, 3) != 0);
        wb_valid  = ($urandom_range(0, 2) == 0);
        wb_rd     = 5'($urandom_range(0, 3));
        flush     = ($urandom_range(0, 24) == 0);
        #1;
        d   = ref_decode(in_instr);
        haz = in_valid && d.legal && ((d.ctrl[6] && m_busy[in_instr[19:15]]) ||
                                      (d.ctrl[5] && m_busy[in_instr[24:20]]));
        rdy = !flush && !haz && (!m_valid || out_ready);
        chk("r_in_ready", a_in_ready, rdy);
        chk("r_in_ready64", b_in_ready, rdy);
        acc = in_valid && rdy;
        if (haz && !flush && m_stall < 65535) m_stall++;
        if (flush) begin
            m_valid = 0;
            m_busy  = '0;
        end else begin
            if (wb_valid) m_busy[wb_rd] = 1'b0;
            if (acc && d.legal && d.ctrl[7] && in_instr[11:7] != 5'd0) m_busy[in_instr[11:7]] = 1'b1;
            if (acc) begin
                m_valid = 1; m_d = d; m_instr = in_instr; m_pc = in_pc;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        tick();
        chk("r_valid", a_out_valid, m_valid);
        chk("r_valid64", b_out_valid, m_valid);
        chk("r_stall", a_stall_cnt, m_stall);
        if (m_valid) begin
            chk("r_type", a_out_type, m_d.ty);
            chk("r_ctrl", a_out_ctrl, m_d.ctrl);
            chk("r_rd", a_out_rd, m_instr[11:7]);
            chk("r_rs1", a_out_rs1, m_instr[19:15]);
            chk("r_rs2", a_out_rs2, m_instr[24:20]);
            chk("r_imm32", a_out_imm, m_d.imm[31:0]);
            chk("r_imm64", b_out_imm, m_d.imm);
            chk("r_pc32", a_out_pc, m_pc[31:0]);
            chk("r_pc64", b_out_pc, m_pc);
            chk("r_illegal", a_out_illegal, !m_d.legal);
        end
    endtask

    localparam logic [31:0] ADDI_X1  = 32'hFFF00093;
    localparam logic [31:0] ADD_X2   = 32'h00108133;  // add x2,x1,x1
    localparam logic [31:0] LUI_X5   = 32'h000002B7;
    localparam logic [31:0] ADD_X6   = 32'h00528333;  // add x6,x5,x5
    localparam logic [31:0] LUI_X3   = 32'h123451B7;

    vec_t vt [10];

    initial begin
        vt[0] = '{ADDI_X1,      3'd1, 8'hD0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vt[1] = '{32'h001000EF, 3'd5, 8'h99, 64'h0000_0000_0000_0800, 1'b0};
        vt[2] = '{32'hFE000EE3, 3'd3, 8'h78, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vt[3] = '{32'h0000007F, 3'd7, 8'h00, 64'h0,                   1'b1};
        vt[4] = '{LUI_X3,       3'd4, 8'h91, 64'h0000_0000_1234_5000, 1'b0};
        vt[5] = '{32'hFE202C23, 3'd2, 8'h72, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
        vt[6] = '{32'h41F0D293, 3'd1, 8'hD0, 64'h0000_0000_0000_001F, 1'b0};
        vt[7] = '{ADD_X2,       3'd0, 8'hE0, 64'h0,                   1'b0};
        vt[8] = '{32'h00000012, 3'd7, 8'h00, 64'h0,                   1'b1};
        vt[9] = '{32'h80000097, 3'd4, 8'h91, 64'hFFFF_FFFF_8000_0000, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = 5'd0; in_instr = ADDI_X1; in_pc = 64'h0;
        tick();
        tick();
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_valid", a_out_valid, 0);
        chk("rst_type", a_out_type, 7);
        chk("rst_ctrl", a_out_ctrl, 0);
        chk("rst_rd", a_out_rd, 0);
        chk("rst_imm", a_out_imm, 0);
        chk("rst_pc", a_out_pc, 0);
        chk("rst_illegal", a_out_illegal, 0);
        chk("rst_stall", a_stall_cnt, 0);
        rst = 1'b0; in_valid = 1'b0;

        for (int i = 0; i < 10; i++) begin
            clear_sb();
            in_instr = vt[i].instr;
            in_pc    = 64'hA000_0000_0000_1000 + 64'(i * 4);
            in_valid = 1'b1;
            #1;
            chk("vec_in_ready", a_in_ready, 1);
            tick();
            in_valid = 1'b0;
            chk("vec_valid", a_out_valid, 1);
            chk("vec_type", a_out_type, vt[i].ty);
            chk("vec_ctrl", a_out_ctrl, vt[i].ctrl);
            chk("vec_imm32", a_out_imm, vt[i].imm[31:0]);
            chk("vec_imm64", b_out_imm, vt[i].imm);
            chk("vec_illegal", a_out_illegal, vt[i].ill);
            chk("vec_pc32", a_out_pc, in_pc[31:0]);
            chk("vec_pc64", b_out_pc, in_pc);
        end
        chk("vec_stall", a_stall_cnt, 0);

        // RAW stall on x1 until writeback retires it.
        clear_sb();
        in_instr = ADDI_X1; in_pc = 64'h100; in_valid = 1'b1;
        tick();
        chk("haz_first_rd", a_out_rd, 1);
        in_instr = ADD_X2; in_pc = 64'h104;
        #1;
        chk("haz_in_ready0", a_in_ready, 0);
        tick();
        chk("haz_stall1", a_stall_cnt, 1);
        chk("haz_drained", a_out_valid, 0);
        tick();
        chk("haz_stall2", a_stall_cnt, 2);
        wb_valid = 1'b1; wb_rd = 5'd1;
        #1;
        chk("haz_wb_same_cycle", a_in_ready, 0);
        tick();
        chk("haz_stall3", a_stall_cnt, 3);
        wb_valid = 1'b0;
        #1;
        chk("haz_released", a_in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("haz_valid", a_out_valid, 1);
        chk("haz_type", a_out_type, 0);
        chk("haz_rd", a_out_rd, 2);
        chk("haz_stall_hold", a_stall_cnt, 3);

        // Illegal passes through; flush drops held output and scoreboard.
        clear_sb();
        in_instr = LUI_X5; in_valid = 1'b1;
        tick();
        in_instr = 32'h0000007F;
        #1;
        chk("ill_in_ready", a_in_ready, 1);
        tick();
        chk("ill_flag", a_out_illegal, 1);
        chk("ill_type", a_out_type, 7);
        chk("ill_ctrl", a_out_ctrl, 0);
        in_instr = ADD_X6;
        #1;
        chk("ill_x5_busy", a_in_ready, 0);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", a_in_ready, 0);
        tick();
        flush = 1'b0;
        chk("flush_valid", a_out_valid, 0);
        chk("flush_no_stall", a_stall_cnt, 3);
        #1;
        chk("flush_busy_clr", a_in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("flush_next_rd", a_out_rd, 6);

        // Backpressure holds the output register.
        clear_sb();
        in_instr = ADDI_X1; in_pc = 64'h200; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_instr = LUI_X3; in_pc = 64'h204;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", a_in_ready, 0);
            tick();
            chk("bp_valid", a_out_valid, 1);
            chk("bp_type", a_out_type, 1);
            chk("bp_imm64", b_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("bp_pc", a_out_pc, 32'h200);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", a_in_ready, 1);
        tick();
        chk("bp_next_type", a_out_type, 4);
        chk("bp_next_pc", a_out_pc, 32'h204);

        // Reset with a held instruction.
        out_ready = 1'b0; in_valid = 1'b0; rst = 1'b1;
        #1;
        chk("mrst_in_ready", a_in_ready, 0);
        tick();
        rst = 1'b0; out_ready = 1'b1;
        chk("mrst_valid", a_out_valid, 0);
        chk("mrst_stall", a_stall_cnt, 0);
        in_instr = ADD_X2; in_valid = 1'b1;
        #1;
        chk("mrst_busy_clr", a_in_ready, 1);
        tick();
        in_valid = 1'b0;

        // Same-cycle retire and re-claim of x1 leaves it busy.
        clear_sb();
        in_instr = ADDI_X1; in_valid = 1'b1; wb_valid = 1'b1; wb_rd = 5'd1;
        tick();
        wb_valid = 1'b0; in_instr = ADD_X2;
        #1;
        chk("setwins", a_in_ready, 0);
        in_valid = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_valid = 0; m_busy = '0; m_stall = 0;
        for (int n = 0; n < 2000; n++) rand_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
